// File: rtl/tpram_fifo_ctrl_if.sv
// Producer/consumer handshake bundle for tpram_fifo_ctrl.
// The master side is the system driving words in and taking them out; the slave side is the FIFO.
interface tpram_fifo_ctrl_if #(
  parameter int DW = 144
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/tpram_fifo_ctrl.sv
// FIFO controller for the 64x144 two-port SRAM with a 2-entry output skid stage.
// Define TPRAM_FIFO_PEAK_EN to add the peak_cnt occupancy high-water output.
module tpram_fifo_ctrl #(
  parameter int DW = 144,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  tpram_fifo_ctrl_if.slave bus,
  output logic          ram_wceb,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rceb,
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW+1:0] count
`ifdef TPRAM_FIFO_PEAK_EN
  ,
  output logic [AW+1:0] peak_cnt
`endif
);

  localparam logic [AW:0] RAM_FULL = {1'b1, {AW{1'b0}}};

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   ram_cnt;
  logic [1:0]    skid_cnt;
  logic          inflight;
  logic [DW-1:0] skid0;
  logic [DW-1:0] skid1;
  logic [AW+1:0] count_q;

  logic          clr;
  logic          push;
  logic          pop;
  logic          rd;
  logic [1:0]    pending;
  logic [1:0]    tail;
  logic [1:0]    skid_cnt_nxt;
  logic [AW:0]   ram_cnt_nxt;
  logic [AW+1:0] count_nxt;
  logic [DW-1:0] skid0_nxt;
  logic [DW-1:0] skid1_nxt;

  assign clr  = !rst_n || flush;
  assign push = bus.in_valid && bus.in_ready && !clr;
  assign pop  = bus.out_valid && bus.out_ready;

  // Only fetch when the skid is guaranteed a free slot once the returning word lands.
  assign pending = skid_cnt + {1'b0, inflight} - {1'b0, pop};
  assign rd      = (ram_cnt != '0) && (pending < 2'd2) && !clr;
  assign tail    = skid_cnt - {1'b0, pop};

  assign skid_cnt_nxt = tail + {1'b0, inflight};
  assign ram_cnt_nxt  = ram_cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, rd};
  assign count_nxt    = {1'b0, ram_cnt_nxt} + {{(AW+1){1'b0}}, rd}
                      + {{AW{1'b0}}, skid_cnt_nxt};

  always_comb begin
    skid0_nxt = skid0;
    skid1_nxt = skid1;
    if (pop) begin
      skid0_nxt = skid1;
    end
    if (inflight) begin
      if (tail == 2'd0) begin
        skid0_nxt = ram_rdata;
      end else begin
        skid1_nxt = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      skid_cnt <= '0;
      inflight <= 1'b0;
      skid0    <= '0;
      skid1    <= '0;
      count_q  <= '0;
    end else begin
      wptr     <= wptr + {{(AW-1){1'b0}}, push};
      rptr     <= rptr + {{(AW-1){1'b0}}, rd};
      ram_cnt  <= ram_cnt_nxt;
      skid_cnt <= skid_cnt_nxt;
      inflight <= rd;
      skid0    <= skid0_nxt;
      skid1    <= skid1_nxt;
      count_q  <= count_nxt;
    end
  end

  assign bus.in_ready  = (ram_cnt != RAM_FULL);
  assign bus.out_valid = (skid_cnt != 2'd0);
  assign bus.out_data  = skid0;

  assign ram_wceb  = !push;
  assign ram_waddr = wptr;
  assign ram_wdata = bus.in_data;
  assign ram_rceb  = !rd;
  assign ram_raddr = rptr;
  assign count     = count_q;

`ifdef TPRAM_FIFO_PEAK_EN
  localparam int CAP = (2 ** AW) + 2;
  localparam logic [AW+1:0] PEAK_MAX = (AW+2)'(CAP);

  logic [AW+1:0] peak_q;

  // Flush leaves the high-water mark alone; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (!flush && (count_nxt > peak_q)) begin
      peak_q <= (count_nxt >= PEAK_MAX) ? PEAK_MAX : count_nxt;
    end
  end

  assign peak_cnt = peak_q;
`endif

endmodule

// File: tb/tb_tpram_fifo_ctrl.sv
// Scoreboard bench for tpram_fifo_ctrl with a behavioural SRAM model.
// Expected words live in a queue; a negedge monitor compares whatever the DUT presents.
module tb_tpram_fifo_ctrl;

  localparam int DW = 144;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          ram_wceb;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          ram_rceb;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic [AW+1:0] count;
`ifdef TPRAM_FIFO_PEAK_EN
  logic [AW+1:0] peak_cnt;
`endif

  tpram_fifo_ctrl_if #(.DW(DW)) bus ();

  tpram_fifo_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .bus       (bus),
    .ram_wceb  (ram_wceb),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_rceb  (ram_rceb),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .count     (count)
`ifdef TPRAM_FIFO_PEAK_EN
    ,
    .peak_cnt  (peak_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [64];

  always @(posedge clk) begin
    if (!ram_wceb) mem[ram_waddr] <= ram_wdata;
    if (!ram_rceb) ram_rdata <= mem[ram_raddr];
  end

  int            compared   = 0;
  int            mismatched = 0;
  logic [DW-1:0] exp_q [$];
  int            wr_cnt;
  int            rd_cnt;
  int            peak_model;
  bit            m_push;

  task automatic checkOutput(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: FIFO-order scoreboard plus SRAM address sequencing, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      wr_cnt     = 0;
      rd_cnt     = 0;
      peak_model = 0;
    end else begin
      checkOutput("count", DW'(count), DW'(exp_q.size()));
      if (exp_q.size() == 66) checkOutput("in_ready_full", DW'(bus.in_ready), DW'(0));
      if (exp_q.size() < 64)  checkOutput("in_ready_room", DW'(bus.in_ready), DW'(1));
      if (exp_q.size() == 0) begin
        checkOutput("out_valid_empty", DW'(bus.out_valid), DW'(0));
      end else if (bus.out_valid) begin
        checkOutput("out_data", bus.out_data, exp_q[0]);
      end
      m_push = bus.in_valid && bus.in_ready && !flush;
      checkOutput("ram_wceb", DW'(ram_wceb), DW'(!m_push));
      if (m_push) begin
        checkOutput("ram_waddr", DW'(ram_waddr), DW'(wr_cnt % 64));
        checkOutput("ram_wdata", ram_wdata, bus.in_data);
      end
      if (flush) checkOutput("rceb_in_flush", DW'(ram_rceb), DW'(1));
      if (!ram_rceb) begin
        checkOutput("ram_raddr", DW'(ram_raddr), DW'(rd_cnt % 64));
        rd_cnt++;
      end
`ifdef TPRAM_FIFO_PEAK_EN
      checkOutput("peak_cnt", DW'(peak_cnt), DW'(peak_model));
`endif
      if (flush) begin
        exp_q.delete();
        wr_cnt = 0;
        rd_cnt = 0;
      end else begin
        if (bus.out_valid && bus.out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (m_push) begin
          exp_q.push_back(bus.in_data);
          wr_cnt++;
        end
        if (exp_q.size() > peak_model) peak_model = exp_q.size();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic r, input logic f);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = f;
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    applyStimulus(1'b1, '1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("reset_wceb", DW'(ram_wceb), DW'(1));
      checkOutput("reset_rceb", DW'(ram_rceb), DW'(1));
      tick();
    end
    @(negedge clk);
    checkOutput("reset_in_ready", DW'(bus.in_ready), DW'(1));
    checkOutput("reset_out_valid", DW'(bus.out_valid), DW'(0));
    checkOutput("reset_count", DW'(count), DW'(0));
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    while (count != 0 && n < 300) begin
      tick();
      n++;
    end
    checkOutput({nm, "_drained"}, DW'(n < 300), DW'(1));
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  // Push one word into an empty FIFO with fresh pointers and time its arrival.
  task automatic singleWord(input string nm, input logic [DW-1:0] data);
    int lat;
    applyStimulus(1'b1, data, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput({nm, "_wceb"}, DW'(ram_wceb), DW'(0));
    checkOutput({nm, "_waddr"}, DW'(ram_waddr), DW'(0));
    tick();
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput({nm, "_rceb"}, DW'(ram_rceb), DW'(0));
    checkOutput({nm, "_raddr"}, DW'(ram_raddr), DW'(0));
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({nm, "_latency"}, DW'(lat), DW'(3));
    checkOutput({nm, "_data"}, bus.out_data, data);
    @(negedge clk);
    checkOutput({nm, "_count_after"}, DW'(count), DW'(0));
    tick();
  endtask

  initial begin
    bit               took;
    int               accepted;
    int               cyc;
    logic [DW-1:0]    word;

    resetDut();
    tick();

    singleWord("single", 144'hA5);

    // Fill past capacity with the consumer stalled; only 66 should stick.
    for (int i = 0; i < 70; i++) begin
      applyStimulus(1'b1, DW'(i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("fill_count", DW'(count), DW'(66));
    checkOutput("fill_in_ready", DW'(bus.in_ready), DW'(0));
    tick();
    drain("fill");

    for (int i = 0; i < 200; i++) begin
      applyStimulus(1'b1, DW'(1000 + i), 1'b1, 1'b0);
      @(negedge clk);
      if (i >= 3) checkOutput("stream_out_valid", DW'(bus.out_valid), DW'(1));
      tick();
    end
    drain("stream");

    accepted = 0;
    cyc      = 0;
    took     = 1'b1;
    word     = '0;
    bus.in_valid = 1'b0;
    while (accepted < 500 && cyc < 10000) begin
      if (!bus.in_valid || took) begin
        word = {$urandom, $urandom, $urandom, $urandom, $urandom};
        applyStimulus($urandom_range(0, 3) != 0, word, $urandom_range(0, 1) == 1, 1'b0);
      end else begin
        bus.out_ready = $urandom_range(0, 1) == 1;
      end
      @(negedge clk);
      took = bus.in_valid && bus.in_ready;
      if (took) accepted++;
      tick();
      cyc++;
    end
    checkOutput("bp_accepted", DW'(accepted), DW'(500));
    drain("bp");

    resetDut();
    tick();
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1'b1, DW'(2000 + i), 1'b0, 1'b0);
      tick();
    end
    applyStimulus(1'b1, DW'(2030), 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("pre_flush_read", DW'(ram_rceb), DW'(0));
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("flush_cycle_count", DW'(count), DW'(30));
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("post_flush_count", DW'(count), DW'(0));
    checkOutput("post_flush_valid", DW'(bus.out_valid), DW'(0));
`ifdef TPRAM_FIFO_PEAK_EN
    checkOutput("post_flush_peak", DW'(peak_cnt), DW'(30));
`endif
    tick();
    singleWord("after_flush", 144'h1);
    drain("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #1000000;
    mismatched++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
